// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, FSM encoding, decode helpers.
// Shift opcodes are only decoded when CPU_SHIFT_EN is defined.
package cpu_pkg;

  typedef enum logic [2:0] {
    RESET_IDLE = 3'd0,
    FETCH_OP   = 3'd1,
    FETCH_OPND = 3'd2,
    MEM_RD     = 3'd3,
    MEM_WR     = 3'd4,
    EXECUTE    = 3'd5,
    HALT       = 3'd6
  } state_e;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_LDA = 8'h02;
  localparam logic [7:0] OP_STA = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_SUB = 8'h05;
  localparam logic [7:0] OP_AND = 8'h06;
  localparam logic [7:0] OP_OR  = 8'h07;
  localparam logic [7:0] OP_XOR = 8'h08;
  localparam logic [7:0] OP_JMP = 8'h09;
  localparam logic [7:0] OP_JZ  = 8'h0A;
  localparam logic [7:0] OP_JC  = 8'h0B;
  localparam logic [7:0] OP_SHL = 8'h0C;
  localparam logic [7:0] OP_SHR = 8'h0D;
  localparam logic [7:0] OP_HLT = 8'hFF;

  function automatic logic [1:0] instr_len(input logic [7:0] op);
    return (op >= OP_LDI && op <= OP_JC) ? 2'd2 : 2'd1;
  endfunction

  // Opcodes whose second operand comes from a data read at address a.
  function automatic logic is_mem_rd(input logic [7:0] op);
    return (op == OP_LDA) || (op >= OP_ADD && op <= OP_XOR);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the accumulator CPU; returns result, zero and carry/borrow.
// SHL/SHR are decoded only when CPU_SHIFT_EN is defined.
import cpu_pkg::*;

module cpu_alu (
  input  logic [7:0] op_i,
  input  logic [7:0] acc_i,
  input  logic [7:0] opnd_i,
  output logic [7:0] res_o,
  output logic       z_o,
  output logic       c_o
);

  always_comb begin
    res_o = acc_i;
    c_o   = 1'b0;
    case (op_i)
      OP_LDI, OP_LDA: res_o = opnd_i;
      OP_ADD:         {c_o, res_o} = {1'b0, acc_i} + {1'b0, opnd_i};
      OP_SUB: begin
        res_o = acc_i - opnd_i;
        c_o   = (acc_i < opnd_i);
      end
      OP_AND:         res_o = acc_i & opnd_i;
      OP_OR:          res_o = acc_i | opnd_i;
      OP_XOR:         res_o = acc_i ^ opnd_i;
`ifdef CPU_SHIFT_EN
      OP_SHL: begin
        res_o = {acc_i[6:0], 1'b0};
        c_o   = acc_i[7];
      end
      OP_SHR: begin
        res_o = {1'b0, acc_i[7:1]};
        c_o   = acc_i[0];
      end
`endif
      default: ;
    endcase
    z_o = (res_o == 8'h00);
  end

endmodule

// File: rtl/cpu.sv
// 8-bit accumulator CPU with a ready-handshaked byte memory interface; all outputs registered.
// Optional SHL/SHR instructions are enabled by defining CPU_SHIFT_EN.
import cpu_pkg::*;

module cpu (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in,
  input  logic [7:0]  mem_data_out,
  output logic        memory_read_en,
  output logic        memory_write_en,
  input  logic        mem_ready
);

  state_e      state_q;
  logic [31:0] pc_q, addr_q;
  logic [7:0]  acc_q, op_q, opnd_q, wdata_q;
  logic        z_q, c_q, halted_q, rd_q, wr_q;
  logic [7:0]  alu_res;
  logic        alu_z, alu_c, acc_wr_d, c_wr_d, can_issue_d;
  logic [31:0] pc_seq_d, target_d;

  cpu_alu u_alu (
    .op_i   (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .res_o  (alu_res),
    .z_o    (alu_z),
    .c_o    (alu_c)
  );

  always_comb begin
    pc_seq_d    = pc_q + 32'(instr_len(op_q));
    target_d    = {24'h0, opnd_q};
    can_issue_d = !mem_ready && !halted_q;
    c_wr_d      = (op_q >= OP_ADD && op_q <= OP_XOR);
`ifdef CPU_SHIFT_EN
    c_wr_d      = c_wr_d || (op_q == OP_SHL) || (op_q == OP_SHR);
`endif
    acc_wr_d    = c_wr_d || (op_q == OP_LDI) || (op_q == OP_LDA);
  end

  // A new read is issued only once mem_ready has been seen low after the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RESET_IDLE;
      pc_q     <= '0;
      acc_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      halted_q <= 1'b0;
      op_q     <= '0;
      opnd_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      case (state_q)
        RESET_IDLE: state_q <= FETCH_OP;
        FETCH_OP: begin
          if (!rd_q) begin
            if (can_issue_d) begin
              rd_q   <= 1'b1;
              addr_q <= pc_q;
            end
          end else if (mem_ready) begin
            rd_q    <= 1'b0;
            op_q    <= mem_data_out;
            state_q <= (instr_len(mem_data_out) == 2'd2) ? FETCH_OPND : EXECUTE;
          end
        end
        FETCH_OPND: begin
          if (!rd_q) begin
            if (can_issue_d) begin
              rd_q   <= 1'b1;
              addr_q <= pc_q + 32'd1;
            end
          end else if (mem_ready) begin
            rd_q   <= 1'b0;
            opnd_q <= mem_data_out;
            if (is_mem_rd(op_q)) begin
              state_q <= MEM_RD;
            end else if (op_q == OP_STA) begin
              state_q <= MEM_WR;
              wr_q    <= 1'b1;
              addr_q  <= {24'h0, mem_data_out};
              wdata_q <= acc_q;
            end else begin
              state_q <= EXECUTE;
            end
          end
        end
        MEM_RD: begin
          if (!rd_q) begin
            if (can_issue_d) begin
              rd_q   <= 1'b1;
              addr_q <= target_d;
            end
          end else if (mem_ready) begin
            rd_q    <= 1'b0;
            opnd_q  <= mem_data_out;
            state_q <= EXECUTE;
          end
        end
        MEM_WR: begin
          wr_q    <= 1'b0;
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          state_q <= FETCH_OP;
          pc_q    <= pc_seq_d;
          if (acc_wr_d) begin
            acc_q <= alu_res;
            z_q   <= alu_z;
          end
          if (c_wr_d) c_q <= alu_c;
          case (op_q)
            OP_JMP: pc_q <= target_d;
            OP_JZ:  if (z_q) pc_q <= target_d;
            OP_JC:  if (c_q) pc_q <= target_d;
            OP_HLT: begin
              state_q  <= HALT;
              halted_q <= 1'b1;
              pc_q     <= pc_q;
            end
            default: ;
          endcase
        end
        HALT: begin
          rd_q <= 1'b0;
          wr_q <= 1'b0;
        end
        default: state_q <= RESET_IDLE;
      endcase
    end
  end

  assign mem_addr        = addr_q;
  assign mem_data_in     = wdata_q;
  assign memory_read_en  = rd_q;
  assign memory_write_en = wr_q;

endmodule

// File: tb/tb_cpu.sv
// Directed testbench for the accumulator CPU with a ready-handshaked byte memory model.
// Expected shift results follow CPU_SHIFT_EN.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        memory_read_en;
  logic        memory_write_en;
  logic        mem_ready = 1'b0;

  logic [7:0]  mem [256];
  logic [31:0] rd_log [64];
  int          rd_cnt, wr_cnt, en_cnt, rise_viol, both_viol;
  logic [31:0] last_wa;
  logic [7:0]  last_wd;
  logic        rd_prev;
  logic        clr = 1'b1;
  int          total = 0;
  int          passed = 0;
  int          snap;
  logic        found;

  cpu dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .memory_read_en  (memory_read_en),
    .memory_write_en (memory_write_en),
    .mem_ready       (mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_addr[7:0]];

  // Memory: ready follows the request by one cycle in both directions.
  always @(posedge clk) begin
    mem_ready <= memory_read_en;
    rd_prev   <= memory_read_en;
    if (clr) begin
      rd_cnt    <= 0;
      wr_cnt    <= 0;
      en_cnt    <= 0;
      rise_viol <= 0;
      both_viol <= 0;
      last_wa   <= '0;
      last_wd   <= '0;
    end else begin
      if (memory_read_en && mem_ready) begin
        if (rd_cnt < 64) rd_log[rd_cnt] <= mem_addr;
        rd_cnt <= rd_cnt + 1;
      end
      if (memory_write_en) begin
        wr_cnt  <= wr_cnt + 1;
        last_wa <= mem_addr;
        last_wd <= mem_data_in;
      end
      if (memory_read_en || memory_write_en) en_cnt <= en_cnt + 1;
      if (memory_read_en && !rd_prev && mem_ready) rise_viol <= rise_viol + 1;
      if (memory_read_en && memory_write_en) both_viol <= both_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
  endtask

  task automatic run;
    repeat (250) @(negedge clk);
  endtask

  task automatic check_protocol(input string tag);
    check({tag, "_rise_while_ready"}, rise_viol, 0);
    check({tag, "_rd_wr_overlap"}, both_viol, 0);
  endtask

  initial begin
    // Test 1: reset behaviour, LDI 5; ADD 0x20; STA 0x21; HLT
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h04; mem[3] = 8'h20;
    mem[4] = 8'h03; mem[5] = 8'h21; mem[6] = 8'hFF; mem[8'h20] = 8'h03;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_rd_en", {31'h0, memory_read_en}, 32'h0);
    check("reset_wr_en", {31'h0, memory_write_en}, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    rst = 1'b0;
    clr = 1'b0;
    run();
    check("t1_first_fetch", rd_log[0], 32'h0);
    check("t1_data_read", rd_log[4], 32'h20);
    check("t1_write_count", wr_cnt, 1);
    check("t1_write_addr", last_wa, 32'h21);
    check("t1_write_data", {24'h0, last_wd}, 32'h08);
    snap = en_cnt;
    repeat (20) @(negedge clk);
    check("t1_quiet_after_hlt", en_cnt, snap);
    check("t1_halt_enables", {30'h0, memory_read_en, memory_write_en}, 32'h0);
    check_protocol("t1");

    // Test 2: LDI 2; SUB 0x20; JC 0x10; @0x10 STA 0x21; HLT
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h05; mem[3] = 8'h20;
    mem[4] = 8'h0B; mem[5] = 8'h10; mem[8'h20] = 8'h03;
    mem[8'h10] = 8'h03; mem[8'h11] = 8'h21; mem[8'h12] = 8'hFF;
    do_reset();
    run();
    check("t2_jc_target_fetch", rd_log[7], 32'h10);
    check("t2_write_addr", last_wa, 32'h21);
    check("t2_sub_result", {24'h0, last_wd}, 32'hFF);
    check("t2_write_count", wr_cnt, 1);
    check_protocol("t2");

    // Test 3: LDI 1; JZ 0x30; AND 0x2F(=0); JC 0x50; JZ 0x40; @0x40 STA 0x23; HLT
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h01; mem[2] = 8'h0A; mem[3] = 8'h30;
    mem[4] = 8'h06; mem[5] = 8'h2F; mem[6] = 8'h0B; mem[7] = 8'h50;
    mem[8] = 8'h0A; mem[9] = 8'h40; mem[8'h2F] = 8'h00;
    mem[8'h40] = 8'h03; mem[8'h41] = 8'h23; mem[8'h42] = 8'hFF;
    mem[8'h30] = 8'h03; mem[8'h31] = 8'h24;
    mem[8'h50] = 8'h03; mem[8'h51] = 8'h24;
    do_reset();
    run();
    check("t3_jz_fallthrough", rd_log[4], 32'h4);
    check("t3_jc_not_taken", rd_log[9], 32'h8);
    check("t3_jz_taken", rd_log[11], 32'h40);
    check("t3_write_addr", last_wa, 32'h23);
    check("t3_and_result", {24'h0, last_wd}, 32'h00);
    check_protocol("t3");

    // Test 4: reset in the middle of a read, then rerun program 1
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h04; mem[3] = 8'h20;
    mem[4] = 8'h03; mem[5] = 8'h21; mem[6] = 8'hFF; mem[8'h20] = 8'h03;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (memory_read_en && rd_cnt >= 3) found = 1'b1;
    end
    check("t4_read_in_flight", {31'h0, found}, 32'h1);
    rst = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("t4_enables_after_rst", {30'h0, memory_read_en, memory_write_en}, 32'h0);
    check("t4_addr_after_rst", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    run();
    check("t4_restart_fetch", rd_log[0], 32'h0);
    check("t4_write_data", {24'h0, last_wd}, 32'h08);
    check_protocol("t4");

    // Test 5: LDI 0x81; SHL; STA 0x22; HLT
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h81; mem[2] = 8'h0C;
    mem[3] = 8'h03; mem[4] = 8'h22; mem[5] = 8'hFF;
    do_reset();
    run();
    check("t5_write_addr", last_wa, 32'h22);
`ifdef CPU_SHIFT_EN
    check("t5_shl_data", {24'h0, last_wd}, 32'h02);
`else
    check("t5_shl_nop_data", {24'h0, last_wd}, 32'h81);
`endif
    check_protocol("t5");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
